// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter that moves a working register by one bit
// per clock.
//
// Operation: a start in IDLE captures A, B and mode. The unit then shifts for
// the captured count, one bit per clock edge. On the following edge it loads
// OUT and pulses done for one cycle. After that it returns to IDLE.
//
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
// Rotate support is built only when the macro SEQ_SHIFTER_ROTATE_EN is
// defined. Without the macro, mode 11 behaves exactly like LSL.
//
// Ports:
//   clk    in   1      clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   abort  in   1      synchronous cancel of an operation in progress
//   A      in   IN_W   operand
//   B      in   AMT_W  unsigned shift amount
//   mode   in   2      shift mode
//   busy   out  1      high while shifting
//   done   out  1      one-cycle registered completion pulse
//   OUT    out  OUT_W  result register, held between completions
module seq_shifter #(
  parameter int IN_W  = 4,
  parameter int AMT_W = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  A,
  input  logic [AMT_W-1:0] B,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] OUT
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_mode;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] work;

  // ASR sign-extends the operand; every other mode zero-extends it.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] a,
                                              input logic [1:0]      m);
    logic signed [IN_W-1:0] a_s;
    a_s = signed'(a);
    if (m == M_ASR) return OUT_W'(a_s);
    return OUT_W'(a);
  endfunction

  // Shifting past the register width cannot change the result any further.
  // The count therefore saturates at OUT_W for the linear shifts. Rotation
  // is periodic in OUT_W, so its count reduces modulo OUT_W.
  function automatic logic [CNT_W-1:0] init_cnt(input logic [AMT_W-1:0] b,
                                                input logic [1:0]       m);
    int bi;
    bi = int'(b);
`ifdef SEQ_SHIFTER_ROTATE_EN
    if (m == M_ROL) return CNT_W'(bi % OUT_W);
`else
    if (m == M_ROL) begin
      // Without rotate support, mode 11 takes the LSL count below.
    end
`endif
    if (bi > OUT_W) return CNT_W'(OUT_W);
    return CNT_W'(bi);
  endfunction

  // Single-bit shift step for the selected mode.
  function automatic logic [OUT_W-1:0] step(input logic [OUT_W-1:0] w,
                                            input logic [1:0]       m);
    logic signed [OUT_W-1:0] w_s;
    logic [OUT_W-1:0]        nxt;
    w_s = signed'(w);
    nxt = w << 1;
    case (m)
      M_LSL: nxt = w << 1;
      M_LSR: nxt = w >> 1;
      M_ASR: nxt = unsigned'(w_s >>> 1);
      M_ROL: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        nxt = {w[OUT_W-2:0], w[OUT_W-1]};
`else
        nxt = w << 1;
`endif
      end
      default: nxt = w << 1;
    endcase
    return nxt;
  endfunction

  assign busy = (state == S_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_mode <= M_LSL;
      cnt     <= '0;
      work    <= '0;
      OUT     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Abort takes priority over a simultaneous start.
          if (start && !abort) begin
            work    <= extend(A, mode);
            cnt     <= init_cnt(B, mode);
            op_mode <= mode;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            OUT   <= work;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            work <= step(work, op_mode);
            cnt  <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Both the normal exit and abort lead back to IDLE with done low.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] OUT;

  int checks;
  int errors;

  seq_shifter #(.IN_W(4), .AMT_W(4), .OUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .A     (A),
    .B     (B),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .OUT   (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request and let the accepting edge occur.
  task automatic launch(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] m);
    A = a; B = b; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full operation: cnt shift edges, then the completion edge.
  task automatic run_op(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] m,
                        input int cnt, input logic [7:0] exp);
    logic seen_done;
    seen_done = 1'b0;
    launch(a, b, m);
    for (int i = 0; i < cnt; i++) begin
      seen_done = seen_done | done;
      tick();
    end
    seen_done = seen_done | done;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_early_done"}, seen_done, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_out"}, OUT, exp);
    tick();
    check({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    logic [7:0] rol_exp;
    logic       seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    A = '0; B = '0; mode = 2'b00;

    #2;
    check("rst_out", OUT, 8'h00);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;

    // LSL 1011 by 2: busy through edges k+1 and k+2, result after k+3.
    launch(4'b1011, 4'd2, 2'b00);
    check("lsl2_busy_k", busy, 1);
    tick();
    check("lsl2_busy_k1", busy, 1);
    check("lsl2_out_held", OUT, 8'h00);
    tick();
    check("lsl2_busy_k2", busy, 1);
    check("lsl2_nodone_k2", done, 0);
    tick();
    check("lsl2_done", done, 1);
    check("lsl2_out", OUT, 8'h2C);
    check("lsl2_busy_off", busy, 0);
    tick();
    check("lsl2_done_clr", done, 0);
    check("lsl2_out_hold", OUT, 8'h2C);

    run_op("lsl9",  4'b1011, 4'd9,  2'b00, 8, 8'h00);
    run_op("asr9",  4'b1000, 4'd9,  2'b10, 8, 8'hFF);
    run_op("asr1",  4'b1000, 4'd1,  2'b10, 1, 8'hFC);
    run_op("lsr1",  4'b1011, 4'd1,  2'b01, 1, 8'h05);
    run_op("lsr15", 4'b1111, 4'd15, 2'b01, 8, 8'h00);
`ifdef SEQ_SHIFTER_ROTATE_EN
    rol_exp = 8'h21;
`else
    rol_exp = 8'h20;
`endif
    run_op("mode11", 4'b1001, 4'd5, 2'b11, 5, rol_exp);

    // B=0: done right after the edge following acceptance; start in DONE ignored.
    launch(4'hF, 4'd0, 2'b00);
    check("b0_busy", busy, 1);
    tick();
    check("b0_done", done, 1);
    check("b0_out", OUT, 8'h0F);
    A = 4'h3; B = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b0_restart_busy", busy, 0);
    check("b0_restart_done", done, 0);
    tick();
    check("b0_restart_idle", busy, 0);
    check("b0_out_hold", OUT, 8'h0F);

    // Abort after two shift edges.
    launch(4'hF, 4'd6, 2'b00);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | done | busy;
    end
    check("abort_quiet", seen, 0);
    check("abort_out", OUT, 8'h0F);

    // Abort together with start in IDLE.
    A = 4'h1; B = 4'd1; mode = 2'b00; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);

    // Reset mid-shift: immediate clear, no done after release.
    launch(4'hF, 4'd6, 2'b00);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out", OUT, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | done | busy;
    end
    check("midrst_quiet", seen, 0);

    // First start after reset is accepted on the first edge.
    run_op("post_rst", 4'b1011, 4'd1, 2'b00, 1, 8'h16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter IN_W, default 4, operand A width.
REQ-002 SHALL have parameter AMT_W, default 4, shift-amount B width.
REQ-003 SHALL have parameter OUT_W, default 8, result width; OUT_W >= IN_W.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-008 SHALL have port A  input  IN_W  operand, captured on accepted start.
REQ-009 SHALL have port B  input  AMT_W  shift amount, unsigned, captured on accepted start.
REQ-010 SHALL have port mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL; captured on accepted start.
REQ-011 SHALL have port busy  output  1  high while state is SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse, registered.
REQ-013 SHALL have port OUT  output  OUT_W  result register, held between completions.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; transitions only on clk rising edge.
REQ-015 IDLE with start=1 and abort=0 SHALL capture A, B, mode and go to SHIFT; start in SHIFT or DONE SHALL be ignored.
REQ-016 On capture, working register SHALL be A zero-extended to OUT_W for LSL/LSR/ROL and sign-extended (A[IN_W-1]) for ASR.
REQ-017 On capture, counter SHALL be min(B, OUT_W) for LSL/LSR/ASR and B mod OUT_W for ROL.
REQ-018 In SHIFT with counter != 0, each edge SHALL shift the working register by exactly one bit per mode and decrement the counter.
REQ-019 LSL and LSR SHALL fill vacated bits with 0; ASR SHALL replicate the MSB; ROL SHALL move the MSB to bit 0.
REQ-020 In SHIFT with counter == 0, the edge SHALL load OUT from the working register, set done=1 and go to DONE.
REQ-021 DONE SHALL last one cycle, then return to IDLE with done=0.
REQ-022 Latency: start accepted at edge k -> done high in the cycle after edge k+cnt+1, where cnt is the REQ-017 count; B=0 gives done after edge k+1.
REQ-023 B >= OUT_W in LSL/LSR SHALL yield OUT=0; in ASR SHALL yield all bits equal to the sign bit.
REQ-024 abort=1 in SHIFT or DONE SHALL force IDLE on the next edge with done=0 and OUT unchanged.
REQ-025 abort=1 together with start=1 in IDLE SHALL ignore start.
REQ-026 OUT SHALL change only on the completion edge (REQ-020) or on reset.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, OUT=0, done=0, busy=0, counter=0, working register=0.
REQ-028 Reset asserted mid-SHIFT SHALL discard the operation; no done pulse SHALL follow reset release.
REQ-029 After rst_n rises, the first start SHALL be accepted at the first clk edge where it is sampled high.

Configuration
REQ-030 Macro SEQ_SHIFTER_ROTATE_EN SHALL control rotate support.
REQ-031 With SEQ_SHIFTER_ROTATE_EN defined, mode 11 SHALL perform ROL per REQ-016 to REQ-019.
REQ-032 Without SEQ_SHIFTER_ROTATE_EN, mode 11 SHALL behave exactly as LSL, and no rotate logic SHALL be built.

Verification (defaults IN_W=4, AMT_W=4, OUT_W=8)
REQ-033 A=4'b1011, B=2, LSL, start at edge k -> busy for edges k+1..k+2; OUT=8'h2C and done=1 after edge k+3.
REQ-034 A=4'b1011, B=9, LSL -> OUT=8'h00 after 8 shift edges. Same inputs with ASR and A=4'b1000 -> OUT=8'hFF. A=4'b1000, B=1, ASR -> OUT=8'hFC. A=4'b1011, B=1, LSR -> OUT=8'h05.
REQ-035 A=4'b1001, B=5, mode 11 -> OUT=8'h21 with the macro defined; OUT=8'h20 without it.
REQ-036 A=4'hF, B=0, LSL -> OUT=8'h0F and done after edge k+1; a second start pulsed during DONE is ignored.
REQ-037 Start A=4'hF, B=6, LSL; assert abort after 2 shift edges -> IDLE, no done, OUT keeps its prior value. Repeat with rst_n pulsed low mid-SHIFT -> OUT=0 and busy=0 immediately, no done after release.
